ask_uart_rx: RTL

Oversampling asynchronous-serial receiver that sits directly downstream of the automatic-threshold ASK detector. It consumes the detector's demodulated `rx` line, which idles high, one sample per detector sample strobe. It recovers start/data/parity/stop framing and delivers each received character on a valid/ready output stream with per-character error flags. Timing is counted in detector samples, not clocks, so the bit rate follows the upstream sample rate.

---
 rtl/ask_uart_pkg.sv | 22 ++
 rtl/ask_uart_bit_sampler.sv | 51 +++++
 rtl/ask_uart_rx.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ask_uart_pkg.sv
// rtl/ask_uart_pkg.sv - shared types and constants for the ASK UART receiver
package ask_uart_pkg;

  // Frame-level receiver states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // PARITY parameter encodings
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Bit positions inside o_tuser
  localparam int TUSER_FRAME_ERR  = 0;
  localparam int TUSER_PARITY_ERR = 1;

endpackage

// File: rtl/ask_uart_bit_sampler.sv
// rtl/ask_uart_bit_sampler.sv - per-bit sample counter and three-sample majority vote
module ask_uart_bit_sampler #(
  parameter int SAMPLES_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_ev,
  input  logic rx,
  input  logic start,
  input  logic run,
  output logic decide,
  output logic bit_val,
  output logic bit_end
);

  localparam int CW = $clog2(SAMPLES_PER_BIT);
  localparam int M  = SAMPLES_PER_BIT / 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLES_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_LO   = CW'(M - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(M);
  localparam logic [CW-1:0] CNT_HI   = CW'(M + 1);

  logic [CW-1:0] cnt_q;
  logic          vote_lo_q;
  logic          vote_mid_q;

  // The start edge itself is sample 0, so the counter is loaded with 1
  // and the next sample event sees cnt = 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      vote_lo_q  <= 1'b1;
      vote_mid_q <= 1'b1;
    end else if (start) begin
      cnt_q <= CW'(1);
    end else if (run && sample_ev) begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      if (cnt_q == CNT_LO)  vote_lo_q  <= rx;
      if (cnt_q == CNT_MID) vote_mid_q <= rx;
    end
  end

  // Third vote is the live sample at the decision point
  always_comb begin
    bit_val = (vote_lo_q & vote_mid_q) | (vote_lo_q & rx) | (vote_mid_q & rx);
    decide  = run & sample_ev & (cnt_q == CNT_HI);
    bit_end = run & sample_ev & (cnt_q == CNT_LAST);
  end

endmodule

// File: rtl/ask_uart_rx.sv
// rtl/ask_uart_rx.sv - oversampling async-serial receiver fed by the ASK detector
module ask_uart_rx
  import ask_uart_pkg::*;
#(
  parameter int SAMPLES_PER_BIT = 16,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 sample_stb,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] o_tdata,
  output logic [1:0]           o_tuser,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic                 overrun,
  output logic                 busy
);

  if (SAMPLES_PER_BIT < 4 || SAMPLES_PER_BIT > 256 ||
      DATA_BITS < 5 || DATA_BITS > 9 ||
      (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN))
  begin : g_param_check
    $error("ask_uart_rx: parameter out of legal range");
  end

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  logic                 rst;
  logic                 ev;
  logic                 run;
  rx_state_t            state_q;
  rx_state_t            state_d;
  logic                 armed_q;
  logic [3:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 perr_q;
  logic                 start_edge;
  logic                 shift_en;
  logic                 par_chk;
  logic                 commit;
  logic                 decide;
  logic                 bit_val;
  logic                 bit_end;
  logic                 ones;
  logic                 parity_bad;
  logic                 pop;

  assign rst  = reset | clear;
  assign ev   = sample_stb & enable;
  assign run  = (state_q != ST_IDLE);
  assign busy = run;
  assign pop  = o_tvalid & o_tready;

  // Odd parity wants an odd total of ones across data plus parity bit
  assign ones       = (^shreg_q) ^ bit_val;
  assign parity_bad = (PARITY == PARITY_ODD) ? ~ones : ones;

  ask_uart_bit_sampler #(
    .SAMPLES_PER_BIT(SAMPLES_PER_BIT)
  ) u_sampler (
    .clk      (clk),
    .reset    (rst),
    .sample_ev(ev),
    .rx       (rx),
    .start    (start_edge),
    .run      (run),
    .decide   (decide),
    .bit_val  (bit_val),
    .bit_end  (bit_end)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and frame control strobes
  always_comb begin
    state_d    = state_q;
    start_edge = 1'b0;
    shift_en   = 1'b0;
    par_chk    = 1'b0;
    commit     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ev && armed_q && !rx) begin
          state_d    = ST_START;
          start_edge = 1'b1;
        end
      end
      ST_START: begin
        if (decide && bit_val) state_d = ST_IDLE;
        else if (bit_end)      state_d = ST_DATA;
      end
      ST_DATA: begin
        shift_en = decide;
        if (bit_end && bit_idx_q == LAST_BIT)
          state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        par_chk = decide;
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Commit at mid-stop so a short stop bit still re-arms in time
        if (decide) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame datapath: arming, bit index, shift register, parity flag
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q   <= 1'b0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      perr_q    <= 1'b0;
    end else begin
      // A stop decision disarms so a stuck-low line cannot retrigger
      if (commit)          armed_q <= 1'b0;
      else if (ev && rx)   armed_q <= 1'b1;

      if (start_edge) begin
        bit_idx_q <= '0;
        perr_q    <= 1'b0;
      end else if (state_q == ST_DATA && bit_end) begin
        bit_idx_q <= bit_idx_q + 1'b1;
      end

      if (shift_en) shreg_q <= {bit_val, shreg_q[DATA_BITS-1:1]};
      if (par_chk)  perr_q  <= parity_bad;
    end
  end

  // Single-entry output register with overrun on a blocked commit
  always_ff @(posedge clk) begin
    if (rst) begin
      o_tdata  <= '0;
      o_tuser  <= '0;
      o_tvalid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit) begin
        if (!o_tvalid || pop) begin
          o_tdata                   <= shreg_q;
          o_tuser[TUSER_PARITY_ERR] <= perr_q;
          o_tuser[TUSER_FRAME_ERR]  <= ~bit_val;
          o_tvalid                  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (pop) begin
        o_tvalid <= 1'b0;
      end
    end
  end

endmodule
